// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and width helpers for the keypad calculator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    localparam logic [3:0] K_ADD = 4'd10;
    localparam logic [3:0] K_SUB = 4'd11;
    localparam logic [3:0] K_MUL = 4'd12;
    localparam logic [3:0] K_DIV = 4'd13;
    localparam logic [3:0] K_MOD = 4'd14;
    localparam logic [3:0] K_EQ  = 4'd15;

    typedef enum logic [2:0] {IDLE, OPA, OPB, CALC, CONV, SHOW} state_t;

    // 10**n as an elaboration-time constant
    function automatic int calc_pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Binary width of one n-digit operand
    function automatic int calc_wb(input int n);
        return $clog2(calc_pow10(n));
    endfunction

    // Binary width of a result (product of two operands)
    function automatic int calc_wr(input int n);
        return 2 * calc_wb(n);
    endfunction

endpackage

// File: rtl/bcd_calc_core_bin2bcd.sv
// Sequential double-dabble: converts a WR-bit binary value to 2*NDIG BCD digits.
// Latency: done pulses WR cycles after the start edge (load and first shift share that edge).
// Backpressure: none; a new start restarts the conversion, bcd holds until the next start.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [calc_wr(NDIG)-1:0] bin,
    output logic [8*NDIG-1:0]     bcd,
    output logic                  done
);
    localparam int WR = calc_wr(NDIG);
    localparam int CW = $clog2(WR + 1);

    logic [WR-1:0]     sh;
    logic [CW-1:0]     cnt;
    logic              run;
    logic [8*NDIG-1:0] adj;

    // Add 3 to every digit that is 5 or more, ahead of the next shift
    function automatic logic [8*NDIG-1:0] dab(input logic [8*NDIG-1:0] v);
        logic [8*NDIG-1:0] o;
        o = v;
        for (int i = 0; i < 2*NDIG; i++) begin
            if (o[4*i +: 4] >= 4'd5) o[4*i +: 4] = o[4*i +: 4] + 4'd3;
        end
        return o;
    endfunction

    assign adj = dab(bcd);

    // One shift per cycle; the first shift happens on the load edge since all digits start at zero
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sh   <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd <= (8*NDIG)'(bin[WR-1]);
                sh  <= {bin[WR-2:0], 1'b0};
                cnt <= CW'(WR - 1);
                run <= 1'b1;
            end else if (run) begin
                bcd <= (8*NDIG)'({adj, sh[WR-1]});
                sh  <= sh << 1;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_calc_core.sv
// Keypad calculator core: NDIG-digit operand entry, add/sub/mul/div/mod, BCD result display.
// Latency: done pulses 3*WB+1 cycles after '=' is accepted (22 for NDIG=2).
// Backpressure: keys are ignored while busy; build with CALC_CHAIN_EN to chain results into a new operation.
module bcd_calc_core
    import calc_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [3:0]        data,
    input  logic              valid,
    output logic [8*NDIG-1:0] bcd_out,
    output logic [3:0]        kout,
    output logic              neg,
    output logic              err,
    output logic              busy,
    output logic              done
);
    localparam int WB = calc_wb(NDIG);
    localparam int WR = calc_wr(NDIG);
    localparam int DW = 4 * NDIG;
    localparam int CW = $clog2(WR + 1);
`ifdef CALC_CHAIN_EN
    localparam int LIM = calc_pow10(NDIG);
`endif

    state_t            state;
    logic              valid_q;
    logic [WB-1:0]     a_bin, b_bin;
    logic [2:0]        a_cnt, b_cnt;
    logic [WR-1:0]     res, mc;
    logic [WB-1:0]     q;
    logic [WB:0]       r;
    logic [CW-1:0]     cnt;
    logic              conv_start, conv_done;
    logic [8*NDIG-1:0] conv_bcd;

    logic              key_acc, is_dig, is_op, is_eq;
    logic [DW-1:0]     ent_app, ent_new;
    logic [WB-1:0]     a_app, b_app;
    logic [WB:0]       r_sh, r_nxt;
    logic              r_ge;
    logic [WB-1:0]     q_nxt;

    // Rising edge of the key strobe, split by key class
    assign key_acc = valid && !valid_q;
    assign is_dig  = key_acc && (data <= 4'd9);
    assign is_op   = key_acc && (data >= K_ADD) && (data <= K_MOD);
    assign is_eq   = key_acc && (data == K_EQ);

    // Entry: BCD shift-in for the display, binary acc*10+d for the datapath
    assign ent_app = DW'({bcd_out[DW-1:0], data});
    assign ent_new = DW'(data);
    assign a_app   = WB'(32'(a_bin) * 10 + 32'(data));
    assign b_app   = WB'(32'(b_bin) * 10 + 32'(data));

    // One restoring-divide step: quotient in q (dividend shifts out MSB first), remainder in r
    assign r_sh  = (WB+1)'({r, q[WB-1]});
    assign r_ge  = r_sh >= {1'b0, b_bin};
    assign r_nxt = r_ge ? (r_sh - {1'b0, b_bin}) : r_sh;
    assign q_nxt = {q[WB-2:0], r_ge};

    // Main FSM: entry, fixed-length calculation, conversion hand-off and result display
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            a_bin      <= '0;
            b_bin      <= '0;
            a_cnt      <= '0;
            b_cnt      <= '0;
            res        <= '0;
            mc         <= '0;
            q          <= '0;
            r          <= '0;
            cnt        <= '0;
            conv_start <= 1'b0;
            bcd_out    <= '0;
            kout       <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            valid_q    <= valid;
            done       <= 1'b0;
            conv_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (is_dig) begin
                        a_bin   <= WB'(data);
                        a_cnt   <= 3'd1;
                        bcd_out <= (8*NDIG)'(ent_new);
                        state   <= OPA;
                    end
                end
                OPA: begin
                    if (is_dig) begin
                        if (a_cnt < 3'(NDIG)) begin
                            a_bin   <= a_app;
                            a_cnt   <= a_cnt + 3'd1;
                            bcd_out <= (8*NDIG)'(ent_app);
                        end
                    end else if (is_op) begin
                        kout  <= data;
                        b_bin <= '0;
                        b_cnt <= '0;
                        state <= OPB;
                    end
                end
                OPB: begin
                    if (is_dig) begin
                        if (b_cnt == 3'd0) begin
                            b_bin   <= WB'(data);
                            b_cnt   <= 3'd1;
                            bcd_out <= (8*NDIG)'(ent_new);
                        end else if (b_cnt < 3'(NDIG)) begin
                            b_bin   <= b_app;
                            b_cnt   <= b_cnt + 3'd1;
                            bcd_out <= (8*NDIG)'(ent_app);
                        end
                    end else if (is_op) begin
                        if (b_cnt == 3'd0) kout <= data;
                    end else if (is_eq) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        res   <= '0;
                        mc    <= WR'(a_bin);
                        q     <= (kout == K_MUL) ? b_bin : a_bin;
                        r     <= '0;
                        neg   <= 1'b0;
                        err   <= ((kout == K_DIV) || (kout == K_MOD)) && (b_bin == '0);
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    case (kout)
                        K_ADD: if (cnt == '0) res <= WR'(a_bin) + WR'(b_bin);
                        K_SUB: if (cnt == '0) begin
                            if (a_bin < b_bin) begin
                                res <= WR'(b_bin) - WR'(a_bin);
                                neg <= 1'b1;
                            end else begin
                                res <= WR'(a_bin) - WR'(b_bin);
                            end
                        end
                        K_MUL: begin
                            if (q[0]) res <= res + mc;
                            mc <= mc << 1;
                            q  <= q >> 1;
                        end
                        default: begin
                            q <= q_nxt;
                            r <= r_nxt;
                            if (cnt == CW'(WB - 1))
                                res <= err ? '0 : ((kout == K_DIV) ? WR'(q_nxt) : WR'(r_nxt));
                        end
                    endcase
                    if (cnt == CW'(WB - 1)) begin
                        state      <= CONV;
                        conv_start <= 1'b1;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state   <= SHOW;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd_out <= conv_bcd;
                    end
                end
                SHOW: begin
                    if (is_dig) begin
                        a_bin   <= WB'(data);
                        a_cnt   <= 3'd1;
                        b_bin   <= '0;
                        b_cnt   <= '0;
                        neg     <= 1'b0;
                        err     <= 1'b0;
                        kout    <= '0;
                        bcd_out <= (8*NDIG)'(ent_new);
                        state   <= OPA;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_op && !neg && !err && (res < WR'(LIM))) begin
                        a_bin <= res[WB-1:0];
                        kout  <= data;
                        b_bin <= '0;
                        b_cnt <= '0;
                        state <= OPB;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    bin2bcd_seq #(.NDIG(NDIG)) u_conv (
        .clk   (clk),
        .clr_n (clr_n),
        .start (conv_start),
        .bin   (res),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

endmodule

// File: tb/tb_bcd_calc_core.sv
// Scoreboard bench for bcd_calc_core (NDIG=2): directed key sequences with hand-computed results.
// Expected results are queued when '=' is pressed; a monitor compares on every done pulse.
// Reset, entry truncation, held-strobe and chaining behaviour are checked directly.
`timescale 1ns/1ps
module tb_bcd_calc_core;
    import calc_pkg::*;

    localparam int NDIG = 2;
    localparam int LAT  = 22;

    logic        clk   = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  data  = 4'd0;
    logic        valid = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  kout;
    logic        neg, err, busy, done;

    bcd_calc_core #(.NDIG(NDIG)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .data    (data),
        .valid   (valid),
        .bcd_out (bcd_out),
        .kout    (kout),
        .neg     (neg),
        .err     (err),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bcd;
        logic        neg;
        logic        err;
        logic [3:0]  kout;
        int          at;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("result_bcd", 32'(bcd_out), 32'(e.bcd));
                chk("result_neg", 32'(neg), 32'(e.neg));
                chk("result_err", 32'(err), 32'(e.err));
                chk("result_kout", 32'(kout), 32'(e.kout));
                chk("done_latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic key(input logic [3:0] k, input int hold = 10);
        @(negedge clk);
        data  = k;
        valid = 1'b1;
        repeat (hold) @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Press '=' and queue the result expected LAT cycles after the accepting edge
    task automatic eq(input logic [15:0] b, input logic n, input logic e_err, input logic [3:0] k);
        exp_t e;
        @(negedge clk);
        data   = K_EQ;
        valid  = 1'b1;
        e.bcd  = b;
        e.neg  = n;
        e.err  = e_err;
        e.kout = k;
        e.at   = cyc + 1 + LAT;
        sb.push_back(e);
        repeat (10) @(negedge clk);
        valid = 1'b0;
        drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bcd"},  32'(bcd_out), 0);
        chk({tag, "_kout"}, 32'(kout), 0);
        chk({tag, "_neg"},  32'(neg), 0);
        chk({tag, "_err"},  32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // 7 + 8 = 15
        key(4'd7); key(K_ADD); key(4'd8);
        eq(16'h0015, 1'b0, 1'b0, K_ADD);

        // 3 - 9 = -6
        key(4'd3); key(K_SUB); key(4'd9);
        eq(16'h0006, 1'b1, 1'b0, K_SUB);

        // 99 * 99 = 9801, maximum product
        key(4'd9);
        chk("show_digit_clears_neg", 32'(neg), 0);
        chk("show_digit_clears_kout", 32'(kout), 0);
        key(4'd9); key(K_MUL); key(4'd9); key(4'd9);
        eq(16'h9801, 1'b0, 1'b0, K_MUL);

        // 47 mod 5 = 2
        key(4'd4); key(4'd7); key(K_MOD); key(4'd5);
        eq(16'h0002, 1'b0, 1'b0, K_MOD);

        // 47 / (empty B) -> divide by zero
        key(4'd4); key(4'd7); key(K_DIV);
        eq(16'h0000, 1'b0, 1'b1, K_DIV);

        // 123 truncates to 12, operator replaced, 12 * 4 = 48
        key(4'd1);
        chk("show_digit_clears_err", 32'(err), 0);
        key(4'd2); key(4'd3);
        chk("entry_truncated", 32'(bcd_out), 32'h0012);
        key(K_ADD); key(K_MUL);
        chk("op_replaced", 32'(kout), 32'(K_MUL));
        key(4'd4);
        chk("b_entry_display", 32'(bcd_out), 32'h0004);
        eq(16'h0048, 1'b0, 1'b0, K_MUL);

        // 6 * 7 = 42, then + 8 either chains or starts a new entry
        key(4'd6); key(K_MUL); key(4'd7);
        eq(16'h0042, 1'b0, 1'b0, K_MUL);
        key(K_ADD); key(4'd8);
`ifdef CALC_CHAIN_EN
        eq(16'h0050, 1'b0, 1'b0, K_ADD);
`else
        key(K_EQ);
        chk("nochain_new_entry", 32'(bcd_out), 32'h0008);
        chk("nochain_kout", 32'(kout), 0);
`endif

        // Async reset in the third CALC cycle
        key(4'd2); key(K_ADD); key(4'd3);
        @(negedge clk);
        data  = K_EQ;
        valid = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("busy_in_calc", 32'(busy), 1);
        clr_n = 1'b0;
        #1;
        chk_reset_outputs("midcalc_reset");
        valid = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Held strobe on digit 5 gives one key, then 5 + 1 = 6
        key(4'd5, 100);
        chk("held_valid_single_key", 32'(bcd_out), 32'h0005);
        key(K_ADD); key(4'd1);
        eq(16'h0006, 1'b0, 1'b0, K_ADD);

        repeat (30) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
